axi_sasd_arbiter: RTL
=====================

// Module: axi_sasd_arbiter
// PURPOSE
//  Bus scheduler for the SASD AXI interconnect. Owns the single shared address/data path.
//  Arbitrates three requesters round-robin: R0 = M0 read (IF), R1 = M1 read (MEM), R2 = M1 write (MEM).
//  Holds the grant until the granted transaction fully completes.
//  Drives one-hot grant and decoded slave select (S0 IM, S1 DM, S2 default slave) to the channel muxes.
// PARAMETERS
//  ADDR_W       32       address width
//  S0_TAG       16'h0000 ADDR[31:16] value selecting slave 0 (IM)
//  S1_TAG       16'h0001 ADDR[31:16] value selecting slave 1 (DM)
//  TIMEOUT_CYC  1024     watchdog limit in cycles; used only with AXI_ARB_TIMEOUT_EN
// PORTS
//  ACLK                   in   1       clock
//  ARESETn                in   1       async active-low reset
//  ARVALID_M0/ARVALID_M1  in   1       read requests R0/R1
//  AWVALID_M1             in   1       write request R2
//  ARADDR_M0/ARADDR_M1    in   ADDR_W  read addresses (decode)
//  AWADDR_M1              in   ADDR_W  write address (decode)
//  ARREADY_M0/ARREADY_M1  in   1       AR handshake, master side of mux
//  AWREADY_M1             in   1       AW handshake
//  RVALID_M0,RREADY_M0,RLAST_M0  in 1  R0 data completion
//  RVALID_M1,RREADY_M1,RLAST_M1  in 1  R1 data completion
//  WVALID_M1,WREADY_M1,WLAST_M1  in 1  write data completion
//  BVALID_M1,BREADY_M1    in   1       write response completion
//  gnt                    out  3       one-hot grant {R2,R1,R0}
//  slv_sel                out  2       0=S0, 1=S1, 2=default slave; 3 never driven
//  is_write               out  1       granted transaction is a write
//  busy                   out  1       any grant held
//  timeout_err            out  1       1-cycle watchdog pulse (tied 0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; round-robin pointer=R0 (R0 highest priority).
//  FSM states: IDLE, AR_WAIT, R_WAIT, AW_WAIT, W_WAIT, B_WAIT.
//  IDLE: on any request, pick the winner, starting from the pointer.
//   - Register gnt, slv_sel, is_write at the next edge; busy=1.
//   - Read winner -> AR_WAIT; write winner -> AW_WAIT.
//   - Pointer moves to winner+1 (mod 3).
//   - Grant latency is 1 cycle after request seen.
//  Decode uses the winner's ADDR[31:16], registered at grant and held constant for the whole grant.
//   - Matches S0_TAG -> 0; matches S1_TAG -> 1; else 2.
//  AR_WAIT -> R_WAIT on ARVALID&ARREADY of the granted master.
//  R_WAIT -> IDLE on RVALID&RREADY&RLAST of the granted master.
//  AW_WAIT -> W_WAIT on AWVALID_M1&AWREADY_M1.
//  W_WAIT -> B_WAIT on WVALID_M1&WREADY_M1&WLAST_M1.
//  B_WAIT -> IDLE on BVALID_M1&BREADY_M1.
//  On the return to IDLE, gnt/busy/is_write/slv_sel clear at the same edge.
//   - At least one idle cycle separates consecutive grants (no back-to-back re-grant).
//  Requests that drop before a grant are ignored; the grant never changes while busy=1.
//  Simultaneous R1 and R2 (M1 read and write) follow the same rotation; no fixed priority.
//  Handshakes before their state (e.g. early WLAST) are ignored; the muxes gate off ungranted paths.
//  ARESETn asserted mid-transaction: immediate async return to reset values; no completion is tracked.
// CONFIGURATION
//  AXI_ARB_TIMEOUT_EN defined:
//   - A counter runs while busy and clears on each state transition.
//   - On reaching TIMEOUT_CYC-1: FSM forced to IDLE, grant dropped, timeout_err pulses 1 cycle.
//   - The pointer still advances.
//  Not defined: no counter logic; timeout_err is constant 0; a hung slave holds the grant forever.
// TESTING
//  1 Reset, then ARVALID_M0 with ARADDR=0x0000_0040 -> gnt=001, slv_sel=0 next cycle.
//    ARREADY, then a 4-beat R with RLAST on beat 4 -> gnt=000 the cycle after the last beat.
//  2 ARVALID_M0, ARVALID_M1, AWVALID_M1 held high from reset -> grants in order 001, 010, 100, 001.
//    Each grant is separated by >=1 idle cycle.
//  3 AWVALID_M1 with AWADDR=0x0001_0008 -> gnt=100, is_write=1, slv_sel=1.
//    WLAST asserted before AWREADY has no effect.
//    Release only after the B handshake.
//  4 ARADDR_M1=0x0002_0000 -> slv_sel=2 (default slave); release on default-slave RLAST.
//  5 ARESETn pulled low during R_WAIT -> gnt=000 and busy=0 asynchronously.
//    After release, the pointer is back at R0.
//  6 (AXI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16) AR granted, ARREADY never asserted.
//    -> timeout_err pulses at cycle 16 of the grant; gnt=000 the same edge.

Source files
------------

// File: rtl/axi_sasd_arbiter_if.sv
// Request and handshake bundle between the SASD channel muxes and the bus scheduler.
// The slave modport is the scheduler side; the master modport drives requests and handshakes.
interface axi_sasd_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              ARVALID_M0;
    logic              ARVALID_M1;
    logic              AWVALID_M1;
    logic [ADDR_W-1:0] ARADDR_M0;
    logic [ADDR_W-1:0] ARADDR_M1;
    logic [ADDR_W-1:0] AWADDR_M1;
    logic              ARREADY_M0;
    logic              ARREADY_M1;
    logic              AWREADY_M1;
    logic              RVALID_M0;
    logic              RREADY_M0;
    logic              RLAST_M0;
    logic              RVALID_M1;
    logic              RREADY_M1;
    logic              RLAST_M1;
    logic              WVALID_M1;
    logic              WREADY_M1;
    logic              WLAST_M1;
    logic              BVALID_M1;
    logic              BREADY_M1;
    logic [2:0]        gnt;
    logic [1:0]        slv_sel;
    logic              is_write;
    logic              busy;
    logic              timeout_err;

    modport master (
        output ARVALID_M0, ARVALID_M1, AWVALID_M1, ARADDR_M0, ARADDR_M1, AWADDR_M1,
        output ARREADY_M0, ARREADY_M1, AWREADY_M1,
        output RVALID_M0, RREADY_M0, RLAST_M0, RVALID_M1, RREADY_M1, RLAST_M1,
        output WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1,
        input  gnt, slv_sel, is_write, busy, timeout_err
    );

    modport slave (
        input  ARVALID_M0, ARVALID_M1, AWVALID_M1, ARADDR_M0, ARADDR_M1, AWADDR_M1,
        input  ARREADY_M0, ARREADY_M1, AWREADY_M1,
        input  RVALID_M0, RREADY_M0, RLAST_M0, RVALID_M1, RREADY_M1, RLAST_M1,
        input  WVALID_M1, WREADY_M1, WLAST_M1, BVALID_M1, BREADY_M1,
        output gnt, slv_sel, is_write, busy, timeout_err
    );
endinterface

// File: rtl/axi_sasd_arbiter.sv
// SASD bus scheduler: round-robin grant of the shared AXI path to M0 read, M1 read, M1 write.
// Optional watchdog is built in when AXI_ARB_TIMEOUT_EN is defined.
module axi_sasd_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [15:0] S0_TAG      = 16'h0000,
    parameter logic [15:0] S1_TAG      = 16'h0001,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic               ACLK,
    input logic               ARESETn,
    axi_sasd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StArWait,
        StRWait,
        StAwWait,
        StWWait,
        StBWait
    } state_e;

    state_e      r_state, w_state_d;
    logic [1:0]  r_ptr, w_ptr_d;
    logic [2:0]  r_gnt, w_gnt_d;
    logic [1:0]  r_slv_sel, w_slv_sel_d;
    logic        r_is_write, w_is_write_d;
    logic [2:0]  w_req;
    logic        w_win_vld;
    logic [1:0]  w_win;
    logic [15:0] w_tag;
    logic        w_ar_hs;
    logic        w_r_done;
    logic        w_timeout;
    logic        w_unused_addr;

    assign w_req = {bus.AWVALID_M1, bus.ARVALID_M1, bus.ARVALID_M0};

    // Scan downward from the farthest offset so the requester nearest the pointer wins.
    always_comb begin
        logic [2:0] idx;
        w_win_vld = 1'b0;
        w_win     = 2'd0;
        idx       = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, r_ptr} + 3'(i);
            if (idx > 3'd2) idx = idx - 3'd3;
            if (w_req[idx[1:0]]) begin
                w_win_vld = 1'b1;
                w_win     = idx[1:0];
            end
        end
    end

    always_comb begin
        case (w_win)
            2'd1:    w_tag = bus.ARADDR_M1[ADDR_W-1 -: 16];
            2'd2:    w_tag = bus.AWADDR_M1[ADDR_W-1 -: 16];
            default: w_tag = bus.ARADDR_M0[ADDR_W-1 -: 16];
        endcase
    end

    assign w_ar_hs  = r_gnt[1] ? (bus.ARVALID_M1 & bus.ARREADY_M1)
                               : (bus.ARVALID_M0 & bus.ARREADY_M0);
    assign w_r_done = r_gnt[1] ? (bus.RVALID_M1 & bus.RREADY_M1 & bus.RLAST_M1)
                               : (bus.RVALID_M0 & bus.RREADY_M0 & bus.RLAST_M0);

    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_gnt_d      = r_gnt;
        w_slv_sel_d  = r_slv_sel;
        w_is_write_d = r_is_write;
        case (r_state)
            StIdle: begin
                if (w_win_vld) begin
                    w_gnt_d      = 3'b001 << w_win;
                    w_is_write_d = (w_win == 2'd2);
                    w_ptr_d      = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
                    w_state_d    = (w_win == 2'd2) ? StAwWait : StArWait;
                    if (w_tag == S0_TAG)      w_slv_sel_d = 2'd0;
                    else if (w_tag == S1_TAG) w_slv_sel_d = 2'd1;
                    else                      w_slv_sel_d = 2'd2;
                end
            end
            StArWait: if (w_ar_hs) w_state_d = StRWait;
            StRWait:  if (w_r_done) w_state_d = StIdle;
            StAwWait: if (bus.AWVALID_M1 && bus.AWREADY_M1) w_state_d = StWWait;
            StWWait:  if (bus.WVALID_M1 && bus.WREADY_M1 && bus.WLAST_M1) w_state_d = StBWait;
            StBWait:  if (bus.BVALID_M1 && bus.BREADY_M1) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
        if (w_timeout) w_state_d = StIdle;
        // Leaving a grant drops it together with its qualifiers at the same edge.
        if (r_state != StIdle && w_state_d == StIdle) begin
            w_gnt_d      = 3'b000;
            w_slv_sel_d  = 2'd0;
            w_is_write_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= StIdle;
            r_ptr      <= 2'd0;
            r_gnt      <= 3'b000;
            r_slv_sel  <= 2'd0;
            r_is_write <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ptr      <= w_ptr_d;
            r_gnt      <= w_gnt_d;
            r_slv_sel  <= w_slv_sel_d;
            r_is_write <= w_is_write_d;
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_timeout_err;

    assign w_timeout = (r_state != StIdle) && (r_cnt == CntW'(TIMEOUT_CYC - 1));
    assign w_cnt_d   = (r_state == StIdle || w_state_d != r_state) ? '0 : r_cnt + CntW'(1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_d;
            r_timeout_err <= w_timeout;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg    = (TIMEOUT_CYC != 0);
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign w_unused_addr = ^{bus.ARADDR_M0[ADDR_W-17:0], bus.ARADDR_M1[ADDR_W-17:0],
                             bus.AWADDR_M1[ADDR_W-17:0]};

    assign bus.gnt      = r_gnt;
    assign bus.slv_sel  = r_slv_sel;
    assign bus.is_write = r_is_write;
    assign bus.busy     = |r_gnt;
endmodule
